qam16_symbol_scheduler: RTL

//  Frame sequencer in front of the 16QAM pulse-shaping filter. Sends a fixed preamble, then pulls

---
 rtl/qam16_symbol_scheduler.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/qam16_symbol_scheduler.sv
// qam16_symbol_scheduler
// Frame sequencer feeding the 16QAM pulse-shaping filter: preamble, FRAME_LEN
// upstream data symbols pulled over ready/valid, then zero flush symbols.
// Each symbol is Gray mapped to signed 3-bit I/Q levels and held for SPS clocks.
// Optional feature: define QAM_SCHED_ABORT_EN to add an abort input that cuts
// the frame short at the next symbol boundary and proceeds straight to FLUSH.
module qam16_symbol_scheduler #(
  parameter int SPS          = 8,
  parameter int PREAMBLE_LEN = 16,
  parameter int FRAME_LEN    = 256,
  parameter int FLUSH_LEN    = 8
) (
  input  logic       clock_5000,
  input  logic       reset,
  input  logic       start,
  input  logic       sym_valid,
  input  logic [3:0] sym_data,
`ifdef QAM_SCHED_ABORT_EN
  input  logic       abort,
`endif
  output logic       sym_ready,
  output logic [2:0] i_level,
  output logic [2:0] q_level,
  output logic       sym_strobe,
  output logic       filt_en,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] underflow
);

  localparam int PH_W    = $clog2(SPS);
  localparam int MAX_LEN = (FRAME_LEN > PREAMBLE_LEN) ?
                           ((FRAME_LEN > FLUSH_LEN) ? FRAME_LEN : FLUSH_LEN) :
                           ((PREAMBLE_LEN > FLUSH_LEN) ? PREAMBLE_LEN : FLUSH_LEN);
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_DATA  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // Gray map of one 2-bit field to a two's-complement level
  function automatic logic [2:0] gray_level(input logic [1:0] bits);
    logic [2:0] lvl;
    case (bits)
      2'b00:   lvl = 3'b101;  // -3
      2'b01:   lvl = 3'b111;  // -1
      2'b11:   lvl = 3'b001;  // +1
      2'b10:   lvl = 3'b011;  // +3
      default: lvl = 3'b000;
    endcase
    return lvl;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [PH_W-1:0]  phase_r, phase_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [2:0]       i_r, q_r, i_nxt_s, q_nxt_s;
  logic             strobe_r, strobe_nxt_s;
  logic             done_r, done_nxt_s;
  logic [7:0]       unf_r, unf_nxt_s;
  logic             pend_r, pend_nxt_s;
  logic             last_phase_s, last_pre_s, last_data_s, last_flush_s;
  logic             abort_now_s, ready_s;

  assign last_phase_s = (phase_r == PH_W'(SPS - 1));
  assign last_pre_s   = (cnt_r == CNT_W'(PREAMBLE_LEN - 1));
  assign last_data_s  = (cnt_r == CNT_W'(FRAME_LEN - 1));
  assign last_flush_s = (cnt_r == CNT_W'(FLUSH_LEN - 1));

`ifdef QAM_SCHED_ABORT_EN
  // A request seen this cycle acts like an already-latched one, so a request
  // arriving on the last phase still closes the handshake and diverts to FLUSH.
  assign abort_now_s = pend_r | (abort & ((state_r == ST_PRE) | (state_r == ST_DATA)));
`else
  assign abort_now_s = 1'b0;
`endif

  // Data slot handshake: only on the last phase before a DATA slot
  assign ready_s = last_phase_s & ~abort_now_s &
                   (((state_r == ST_PRE) & last_pre_s) |
                    ((state_r == ST_DATA) & ~last_data_s));

  // State register
  always_ff @(posedge clock_5000 or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: transitions only at symbol boundaries
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_PRE;
        else       state_nxt_s = ST_IDLE;
      end
      ST_PRE: begin
        if (last_phase_s && abort_now_s)     state_nxt_s = ST_FLUSH;
        else if (last_phase_s && last_pre_s) state_nxt_s = ST_DATA;
        else                                 state_nxt_s = ST_PRE;
      end
      ST_DATA: begin
        if (last_phase_s && (abort_now_s || last_data_s)) state_nxt_s = ST_FLUSH;
        else                                              state_nxt_s = ST_DATA;
      end
      ST_FLUSH: begin
        if (last_phase_s && last_flush_s) state_nxt_s = ST_IDLE;
        else                              state_nxt_s = ST_FLUSH;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output/datapath next values: phase, symbol counter and the next symbol
  always_comb begin
    phase_nxt_s  = phase_r;
    cnt_nxt_s    = cnt_r;
    i_nxt_s      = i_r;
    q_nxt_s      = q_r;
    strobe_nxt_s = 1'b0;
    done_nxt_s   = 1'b0;
    unf_nxt_s    = unf_r;
    pend_nxt_s   = abort_now_s & ((state_nxt_s == ST_PRE) | (state_nxt_s == ST_DATA));
    if (state_r == ST_IDLE) begin
      phase_nxt_s = {PH_W{1'b0}};
      cnt_nxt_s   = {CNT_W{1'b0}};
      if (start) begin
        strobe_nxt_s = 1'b1;
        i_nxt_s      = 3'b011;
        q_nxt_s      = 3'b011;
        unf_nxt_s    = 8'd0;
      end else begin
        i_nxt_s = 3'b000;
        q_nxt_s = 3'b000;
      end
    end else if (last_phase_s) begin
      phase_nxt_s  = {PH_W{1'b0}};
      strobe_nxt_s = (state_nxt_s != ST_IDLE);
      if (state_nxt_s != state_r) cnt_nxt_s = {CNT_W{1'b0}};
      else                        cnt_nxt_s = cnt_r + CNT_W'(1);
      case (state_nxt_s)
        ST_PRE: begin
          // Next preamble index is cnt_r+1: odd when cnt_r is even
          if (cnt_r[0] == 1'b0) begin
            i_nxt_s = 3'b101;
            q_nxt_s = 3'b101;
          end else begin
            i_nxt_s = 3'b011;
            q_nxt_s = 3'b011;
          end
        end
        ST_DATA: begin
          if (sym_valid) begin
            i_nxt_s = gray_level(sym_data[3:2]);
            q_nxt_s = gray_level(sym_data[1:0]);
          end else begin
            i_nxt_s = 3'b000;
            q_nxt_s = 3'b000;
            if (unf_r != 8'hFF) unf_nxt_s = unf_r + 8'd1;
            else                unf_nxt_s = unf_r;
          end
        end
        ST_FLUSH: begin
          i_nxt_s = 3'b000;
          q_nxt_s = 3'b000;
        end
        ST_IDLE: begin
          i_nxt_s    = 3'b000;
          q_nxt_s    = 3'b000;
          done_nxt_s = 1'b1;
        end
        default: begin
          i_nxt_s = 3'b000;
          q_nxt_s = 3'b000;
        end
      endcase
    end else begin
      phase_nxt_s = phase_r + PH_W'(1);
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock_5000 or posedge reset) begin
    if (reset) begin
      phase_r  <= {PH_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      i_r      <= 3'b000;
      q_r      <= 3'b000;
      strobe_r <= 1'b0;
      done_r   <= 1'b0;
      unf_r    <= 8'd0;
      pend_r   <= 1'b0;
    end else begin
      phase_r  <= phase_nxt_s;
      cnt_r    <= cnt_nxt_s;
      i_r      <= i_nxt_s;
      q_r      <= q_nxt_s;
      strobe_r <= strobe_nxt_s;
      done_r   <= done_nxt_s;
      unf_r    <= unf_nxt_s;
      pend_r   <= pend_nxt_s;
    end
  end

  assign sym_ready  = ready_s;
  assign i_level    = i_r;
  assign q_level    = q_r;
  assign sym_strobe = strobe_r;
  assign busy       = (state_r != ST_IDLE);
  assign filt_en    = busy;
  assign frame_done = done_r;
  assign underflow  = unf_r;

endmodule
